// File: rtl/dl11_pkg.sv
// Shared constants for the DL11 serial line controller: register map, CSR bits, FSM encodings.
package dl11_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CHAR_W = 8;
  localparam int unsigned ADDR_W = 2;

  // Register word offsets
  localparam logic [ADDR_W-1:0] ADDR_RCSR = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RBUF = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_XCSR = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_XBUF = 2'd3;

  // CSR bit positions
  localparam int unsigned BIT_DONE  = 7;
  localparam int unsigned BIT_READY = 7;
  localparam int unsigned BIT_IE    = 6;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_REQ  = 2'd1,
    RX_REL  = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REQ  = 2'd1,
    TX_REL  = 2'd2,
    TX_WAIT = 2'd3
  } tx_state_t;

  // Builds a CSR readback word from its status and interrupt-enable bits
  function automatic logic [DATA_W-1:0] csr_word(input logic status, input logic ie);
    logic [DATA_W-1:0] w;
    w           = '0;
    w[BIT_DONE] = status;
    w[BIT_IE]   = ie;
    return w;
  endfunction

endpackage

// File: rtl/dl11_if.sv
// CPU bus, interrupt and UART handshake signals of the DL11 controller.
interface dl11_if;
  import dl11_pkg::*;

  logic              sel;
  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              rx_int_req;
  logic              rx_int_ack;
  logic              tx_int_req;
  logic              tx_int_ack;
  logic              ld_tx_req;
  logic              ld_tx_ack;
  logic [CHAR_W-1:0] tx_data;
  logic              tx_empty;
  logic              uld_rx_req;
  logic              uld_rx_ack;
  logic [CHAR_W-1:0] rx_data;
  logic              rx_empty;

  // Controller side
  modport slave (
    input  sel, addr, rd, wr, data_in, rx_int_ack, tx_int_ack,
           ld_tx_ack, tx_empty, uld_rx_ack, rx_data, rx_empty,
    output data_out, rx_int_req, tx_int_req, ld_tx_req, tx_data, uld_rx_req
  );

  // CPU / UART side
  modport master (
    output sel, addr, rd, wr, data_in, rx_int_ack, tx_int_ack,
           ld_tx_ack, tx_empty, uld_rx_ack, rx_data, rx_empty,
    input  data_out, rx_int_req, tx_int_req, ld_tx_req, tx_data, uld_rx_req
  );

endinterface

// File: rtl/dl11_sync2.sv
// Two-flop synchronizer with a configurable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Resample the asynchronous input twice
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/dl11_ctrl.sv
// DL11 serial line controller: CPU register file, RX/TX UART handshakes, interrupt requests.
module dl11_ctrl
  import dl11_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  dl11_if.slave  bus
);

  logic w_ld_tx_ack_s;
  logic w_uld_rx_ack_s;
  logic w_tx_empty_s;
  logic w_rx_empty_s;

  sync2 #(.RST_VAL(1'b0)) u_sync_ld_ack  (.clk(clk), .reset_n(reset_n), .i_d(bus.ld_tx_ack),  .o_q(w_ld_tx_ack_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_uld_ack (.clk(clk), .reset_n(reset_n), .i_d(bus.uld_rx_ack), .o_q(w_uld_rx_ack_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_tx_emp  (.clk(clk), .reset_n(reset_n), .i_d(bus.tx_empty),   .o_q(w_tx_empty_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_rx_emp  (.clk(clk), .reset_n(reset_n), .i_d(bus.rx_empty),   .o_q(w_rx_empty_s));

  logic [DATA_W-1:0] r_data_out;
  logic [CHAR_W-1:0] r_rbuf;
  logic [CHAR_W-1:0] r_tx_data;
  logic              r_rx_done;
  logic              r_rx_ie;
  logic              r_tx_ie;
  logic              r_xmit_ready;
  logic              r_ld_tx_req;
  logic              r_uld_rx_req;
  logic              r_rx_int_req;
  logic              r_tx_int_req;
  logic              r_rx_cond_q;
  logic              r_tx_cond_q;
  rx_state_t         r_rx_state;
  tx_state_t         r_tx_state;

  logic w_rd;
  logic w_wr;
  logic w_rbuf_rd;
  logic w_xbuf_wr;
  logic w_rx_load;
  logic w_tx_done;
  logic w_rx_cond;
  logic w_tx_cond;
  logic w_unused_ok;

  assign w_rd        = bus.sel & bus.rd;
  assign w_wr        = bus.sel & bus.wr;
  assign w_rbuf_rd   = w_rd & (bus.addr == ADDR_RBUF);
  // Only the registered ready flag gates an XBUF write
  assign w_xbuf_wr   = w_wr & (bus.addr == ADDR_XBUF) & r_xmit_ready;
  assign w_rx_load   = (r_rx_state == RX_REL) & ~w_uld_rx_ack_s;
  assign w_tx_done   = (r_tx_state == TX_WAIT) & w_tx_empty_s;
  assign w_rx_cond   = r_rx_done & r_rx_ie;
  assign w_tx_cond   = r_xmit_ready & r_tx_ie;
  assign w_unused_ok = ^bus.data_in[DATA_W-1:CHAR_W];

  // Registered read data, updated only on a selected read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= '0;
    end else if (w_rd) begin
      case (bus.addr)
        ADDR_RCSR: r_data_out <= csr_word(r_rx_done, r_rx_ie);
        ADDR_RBUF: r_data_out <= DATA_W'(r_rbuf);
        ADDR_XCSR: r_data_out <= csr_word(r_xmit_ready, r_tx_ie);
        default:   r_data_out <= '0;
      endcase
    end
  end

  // Interrupt-enable bits from CSR writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_ie <= 1'b0;
      r_tx_ie <= 1'b0;
    end else if (w_wr) begin
      if (bus.addr == ADDR_RCSR) r_rx_ie <= bus.data_in[BIT_IE];
      if (bus.addr == ADDR_XCSR) r_tx_ie <= bus.data_in[BIT_IE];
    end
  end

  // RX unload handshake; character captured as the ack is released
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_state   <= RX_IDLE;
      r_uld_rx_req <= 1'b0;
      r_rbuf       <= '0;
    end else begin
      case (r_rx_state)
        RX_IDLE: if (!w_rx_empty_s && !r_rx_done && !w_uld_rx_ack_s) begin
          r_rx_state   <= RX_REQ;
          r_uld_rx_req <= 1'b1;
        end
        RX_REQ: if (w_uld_rx_ack_s) begin
          r_rx_state   <= RX_REL;
          r_uld_rx_req <= 1'b0;
        end
        RX_REL: if (!w_uld_rx_ack_s) begin
          r_rx_state <= RX_IDLE;
          r_rbuf     <= bus.rx_data;
        end
        default: begin
          r_rx_state   <= RX_IDLE;
          r_uld_rx_req <= 1'b0;
        end
      endcase
    end
  end

  // Receive-done flag: set on capture (wins), cleared by an RBUF read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_rx_done <= 1'b0;
    else if (w_rx_load) r_rx_done <= 1'b1;
    else if (w_rbuf_rd) r_rx_done <= 1'b0;
  end

  // TX load handshake, started by a cleared ready flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state  <= TX_IDLE;
      r_ld_tx_req <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: if (!r_xmit_ready && !w_ld_tx_ack_s) begin
          r_tx_state  <= TX_REQ;
          r_ld_tx_req <= 1'b1;
        end
        TX_REQ: if (w_ld_tx_ack_s) begin
          r_tx_state  <= TX_REL;
          r_ld_tx_req <= 1'b0;
        end
        TX_REL:  if (!w_ld_tx_ack_s) r_tx_state <= TX_WAIT;
        TX_WAIT: if (w_tx_empty_s)   r_tx_state <= TX_IDLE;
        default: begin
          r_tx_state  <= TX_IDLE;
          r_ld_tx_req <= 1'b0;
        end
      endcase
    end
  end

  // Transmit character latch and ready flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_data    <= '0;
      r_xmit_ready <= 1'b1;
    end else if (w_xbuf_wr) begin
      r_tx_data    <= bus.data_in[CHAR_W-1:0];
      r_xmit_ready <= 1'b0;
    end else if (w_tx_done) begin
      r_xmit_ready <= 1'b1;
    end
  end

  // Interrupt requests: set on rising condition, cleared by ack or falling condition
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_cond_q  <= 1'b0;
      r_tx_cond_q  <= 1'b0;
      r_rx_int_req <= 1'b0;
      r_tx_int_req <= 1'b0;
    end else begin
      r_rx_cond_q <= w_rx_cond;
      r_tx_cond_q <= w_tx_cond;
      if (!w_rx_cond || bus.rx_int_ack) r_rx_int_req <= 1'b0;
      else if (!r_rx_cond_q)            r_rx_int_req <= 1'b1;
      if (!w_tx_cond || bus.tx_int_ack) r_tx_int_req <= 1'b0;
      else if (!r_tx_cond_q)            r_tx_int_req <= 1'b1;
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.tx_data    = r_tx_data;
  assign bus.ld_tx_req  = r_ld_tx_req;
  assign bus.uld_rx_req = r_uld_rx_req;
  assign bus.rx_int_req = r_rx_int_req;
  assign bus.tx_int_req = r_tx_int_req;

endmodule

// File: tb/tb_dl11_ctrl.sv
// Directed self-checking bench for dl11_ctrl.
module tb_dl11_ctrl;
  import dl11_pkg::*;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  dl11_if bus();

  dl11_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.data_in = d;
    @(negedge clk);
    bus.sel = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [15:0] v);
    @(negedge clk);
    bus.sel = 1'b1; bus.rd = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.sel = 1'b0; bus.rd = 1'b0;
    v = bus.data_out;
  endtask

  // 0 uld_rx_req, 1 ld_tx_req, 2 rx_int_req, 3 tx_int_req
  function automatic logic pick(input int which);
    case (which)
      0:       return bus.uld_rx_req;
      1:       return bus.ld_tx_req;
      2:       return bus.rx_int_req;
      default: return bus.tx_int_req;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, input string tag);
    logic got;
    got = ~val;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      got = pick(which);
      if (got === val) break;
    end
    check(tag, 16'(got), 16'(val));
  endtask

  task automatic uart_rx(input logic [7:0] ch, input string tag);
    @(negedge clk);
    bus.rx_data = ch; bus.rx_empty = 1'b0;
    wait_for(0, 1'b1, {tag, "_req_up"});
    @(negedge clk);
    bus.uld_rx_ack = 1'b1;
    wait_for(0, 1'b0, {tag, "_req_down"});
    @(negedge clk);
    bus.rx_empty = 1'b1; bus.uld_rx_ack = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [15:0] v;
    int          pulses;
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus.sel = 1'b0; bus.addr = '0; bus.rd = 1'b0; bus.wr = 1'b0; bus.data_in = '0;
    bus.rx_int_ack = 1'b0; bus.tx_int_ack = 1'b0;
    bus.ld_tx_ack = 1'b0; bus.uld_rx_ack = 1'b0;
    bus.tx_empty = 1'b1; bus.rx_empty = 1'b1; bus.rx_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data_out", bus.data_out, 16'h0000);
    check("rst_tx_data", 16'(bus.tx_data), 16'h0000);
    check("rst_reqs", 16'({bus.ld_tx_req, bus.uld_rx_req, bus.rx_int_req, bus.tx_int_req}), 16'h0000);
    reset_n = 1'b1;
    cpu_read(ADDR_XCSR, v); check("rst_xcsr", v, 16'h0080);
    cpu_read(ADDR_RCSR, v); check("rst_rcsr", v, 16'h0000);
    cpu_read(ADDR_RBUF, v); check("rst_rbuf", v, 16'h0000);

    // Receive 0x41
    uart_rx(8'h41, "rx41");
    check("rx41_no_rereq", 16'(bus.uld_rx_req), 16'h0000);
    cpu_read(ADDR_RCSR, v); check("rx41_rcsr", v, 16'h0080);
    cpu_read(ADDR_RBUF, v); check("rx41_rbuf", v, 16'h0041);
    cpu_read(ADDR_RCSR, v); check("rx41_rcsr_clr", v, 16'h0000);
    cpu_read(ADDR_XBUF, v); check("xbuf_read", v, 16'h0000);

    // Transmit 0x5A
    cpu_read(ADDR_XCSR, v); check("tx_xcsr_rdy", v, 16'h0080);
    cpu_write(ADDR_XBUF, 16'h1F5A);
    check("tx_data_5a", 16'(bus.tx_data), 16'h005A);
    cpu_read(ADDR_XCSR, v); check("tx_xcsr_busy", v, 16'h0000);
    wait_for(1, 1'b1, "tx_ld_req_up");
    @(negedge clk);
    bus.tx_empty = 1'b0; bus.ld_tx_ack = 1'b1;
    wait_for(1, 1'b0, "tx_ld_req_down");
    @(negedge clk);
    bus.ld_tx_ack = 1'b0;
    repeat (6) @(negedge clk);
    cpu_read(ADDR_XCSR, v); check("tx_xcsr_wait", v, 16'h0000);

    // Discarded write while busy
    cpu_write(ADDR_XBUF, 16'h0033);
    check("tx_data_keep", 16'(bus.tx_data), 16'h005A);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ld_tx_req) pulses++;
    end
    check("tx_no_ld_pulse", 16'(pulses), 16'h0000);
    bus.tx_empty = 1'b1;
    repeat (5) @(negedge clk);
    cpu_read(ADDR_XCSR, v); check("tx_xcsr_done", v, 16'h0080);

    // Receive interrupt
    cpu_write(ADDR_RCSR, 16'h0040);
    cpu_read(ADDR_RCSR, v); check("rxie_rcsr", v, 16'h0040);
    check("rxint_idle", 16'(bus.rx_int_req), 16'h0000);
    uart_rx(8'h0D, "rx0d");
    wait_for(2, 1'b1, "rxint_set");
    @(negedge clk);
    bus.rx_int_ack = 1'b1;
    @(negedge clk);
    bus.rx_int_ack = 1'b0;
    check("rxint_ack_clr", 16'(bus.rx_int_req), 16'h0000);
    repeat (3) @(negedge clk);
    check("rxint_stays_clr", 16'(bus.rx_int_req), 16'h0000);
    cpu_read(ADDR_RCSR, v); check("rxint_rcsr", v, 16'h00C0);
    cpu_read(ADDR_RBUF, v); check("rx0d_rbuf", v, 16'h000D);
    cpu_write(ADDR_RCSR, 16'h0000);

    // Transmit interrupt via IE set while ready
    cpu_write(ADDR_XCSR, 16'h0040);
    @(negedge clk);
    check("txint_set", 16'(bus.tx_int_req), 16'h0001);
    cpu_write(ADDR_XCSR, 16'h0000);
    @(negedge clk);
    check("txint_clr", 16'(bus.tx_int_req), 16'h0000);

    // Reset mid-handshake with ack held high
    @(negedge clk);
    bus.rx_data = 8'h55; bus.rx_empty = 1'b0;
    wait_for(0, 1'b1, "rst_hs_req_up");
    @(negedge clk);
    bus.uld_rx_ack = 1'b1;
    #1 reset_n = 1'b0;
    #1 check("rst_hs_req_drop", 16'(bus.uld_rx_req), 16'h0000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.uld_rx_req) pulses++;
    end
    check("rst_hs_no_req", 16'(pulses), 16'h0000);
    bus.uld_rx_ack = 1'b0;
    wait_for(0, 1'b1, "rst_hs_restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
